// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: sequencer for one output-stationary accumulator of the
// 16-bit binary-parallel PE. It counts i_len operand beats, emits an
// accumulator enable and a first-beat clear-select delayed by PIPE_LAT to
// line up with the MAC output, waits for the pipeline to drain and then holds
// the result under a valid/ready handshake.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   i_start      start a reduction (honoured only when idle)
//   i_len        number of beats, latched on an accepted start
//   i_valid      upstream operand beat valid
//   o_ready      controller accepting operand beats
//   o_acc_en     accumulator enable, aligned to MAC output
//   o_acc_clr    zero the feedback operand (first beat), aligned with o_acc_en
//   o_out_valid  accumulator holds the final result
//   i_out_ready  downstream consumes the result
//   o_done       one-cycle pulse after the result handshake
//   o_busy       controller not idle
//   o_cnt        beats accepted in the current reduction
module acc_seq_ctrl #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned PIPE_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_len,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_acc_en,
    output logic                 o_acc_clr,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic                 o_done,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    // Drain counter only needs to reach PIPE_LAT-1.
    localparam int unsigned DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [PIPE_LAT-1:0]  en_pipe_q;
    logic [PIPE_LAT-1:0]  clr_pipe_q;

    logic ready_q, ready_d;
    logic out_valid_q, out_valid_d;
    logic done_q, done_d;
    logic busy_q, busy_d;

    logic beat_c;
    logic first_c;
    logic last_beat_c;
    logic drain_end_c;
    logic start_ok_c;
    logic handshake_c;

    // Event decode shared by the FSM, counters and delay line.
    assign beat_c      = i_valid && (state_q == S_ACC);
    assign first_c     = beat_c && (cnt_q == '0);
    assign last_beat_c = beat_c && (cnt_q == (len_q - CNT_WIDTH'(1)));
    assign drain_end_c = (drain_q == DRAIN_W'(PIPE_LAT - 1));
    assign start_ok_c  = i_start && (i_len != '0);
    assign handshake_c = (state_q == S_OUT) && i_out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok_c) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (last_beat_c) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_end_c) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (i_out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        ready_d     = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = handshake_c;
        case (state_d)
            S_ACC: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            S_DRAIN: begin
                busy_d = 1'b1;
            end
            S_OUT: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // Length latch, beat counter and drain counter next-state.
    always_comb begin
        len_d   = len_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        if ((state_q == S_IDLE) && start_ok_c) begin
            len_d = i_len;
            cnt_d = '0;
        end
        if (beat_c) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        // Drain counter self-clears on exit so it starts at zero next time.
        if (state_q == S_DRAIN) begin
            drain_d = drain_end_c ? '0 : (drain_q + DRAIN_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    // Beat / first-beat delay line matching the MAC pipeline depth.
    generate
        if (PIPE_LAT == 1) begin : g_pipe_one
            always_ff @(posedge clk) begin
                if (rst) begin
                    en_pipe_q  <= '0;
                    clr_pipe_q <= '0;
                end else begin
                    en_pipe_q  <= beat_c;
                    clr_pipe_q <= first_c;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    en_pipe_q  <= '0;
                    clr_pipe_q <= '0;
                end else begin
                    en_pipe_q  <= {en_pipe_q[PIPE_LAT-2:0], beat_c};
                    clr_pipe_q <= {clr_pipe_q[PIPE_LAT-2:0], first_c};
                end
            end
        end
    endgenerate

    assign o_ready     = ready_q;
    assign o_acc_en    = en_pipe_q[PIPE_LAT-1];
    assign o_acc_clr   = clr_pipe_q[PIPE_LAT-1];
    assign o_out_valid = out_valid_q;
    assign o_done      = done_q;
    assign o_busy      = busy_q;
    assign o_cnt       = cnt_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Testbench for acc_seq_ctrl: randomized and directed reductions checked
// against a job-level reference model through expectation queues.
module tb_acc_seq_ctrl;

    localparam int unsigned CW = 8;
    localparam int          PL = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [CW-1:0] i_len;
    logic          i_valid;
    logic          o_ready;
    logic          o_acc_en;
    logic          o_acc_clr;
    logic          o_out_valid;
    logic          i_out_ready;
    logic          o_done;
    logic          o_busy;
    logic [CW-1:0] o_cnt;
    logic [15:0]   i_data;

    always #5 clk = ~clk;

    acc_seq_ctrl #(.CNT_WIDTH(CW), .PIPE_LAT(PL)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_len       (i_len),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_acc_en    (o_acc_en),
        .o_acc_clr   (o_acc_clr),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_cnt       (o_cnt)
    );

    typedef struct {
        bit          chk;
        bit          ready;
        bit          busy;
        bit          en;
        bit          clr;
        bit          ov;
        bit          done;
        int unsigned cnt;
    } exp_t;

    typedef struct {
        int c;
        bit first;
    } beat_t;

    exp_t        q_exp[$];
    int unsigned q_res[$];
    beat_t       pend[$];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s timeout cyc=%0d", name, cyc);
        finish_run();
    endtask

    // Reference model: job bookkeeping per cycle, sampled mid-cycle.
    bit          m_valid = 0;
    bit          m_active = 0;
    bit          m_out_pending = 0;
    int          m_len = 0;
    int          m_beats = 0;
    int          m_cnt = 0;
    int          m_out_cyc = 0;
    int          m_done_cyc = -10;
    int unsigned m_sum = 0;

    always @(negedge clk) begin
        exp_t e;
        bit   beat;
        e.chk   = m_valid;
        e.ready = m_active && (m_beats < m_len);
        e.busy  = m_active;
        e.cnt   = m_cnt;
        e.en    = (pend.size() > 0) && (pend[0].c == cyc);
        e.clr   = e.en ? pend[0].first : 1'b0;
        if (e.en) void'(pend.pop_front());
        e.ov    = m_out_pending && (cyc >= m_out_cyc);
        e.done  = (cyc == m_done_cyc);
        q_exp.push_back(e);
        if (rst) begin
            m_valid       = 1;
            m_active      = 0;
            m_out_pending = 0;
            m_len         = 0;
            m_beats       = 0;
            m_cnt         = 0;
            m_done_cyc    = -10;
            pend.delete();
            q_res.delete();
        end else if (m_valid) begin
            beat = i_valid && e.ready;
            if (beat) begin
                pend.push_back('{cyc + PL, m_beats == 0});
                m_sum += 32'(i_data);
                m_beats++;
                m_cnt++;
                if (m_beats == m_len) begin
                    m_out_pending = 1;
                    m_out_cyc     = cyc + 1 + PL;
                    q_res.push_back(m_sum);
                end
            end
            if (e.ov && i_out_ready) begin
                m_out_pending = 0;
                m_active      = 0;
                m_done_cyc    = cyc + 1;
            end
            if (!e.busy && i_start && (i_len != '0)) begin
                m_active = 1;
                m_len    = int'(i_len);
                m_beats  = 0;
                m_cnt    = 0;
                m_sum    = 0;
            end
        end
    end

    // Monitor: compares control outputs and the accumulated result.
    int unsigned acc = 0;
    logic [15:0] opd [PL];

    always @(negedge clk) begin
        exp_t        e;
        int unsigned op;
        #1;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            if (e.chk) begin
                check("o_ready",     32'(o_ready),     32'(e.ready));
                check("o_busy",      32'(o_busy),      32'(e.busy));
                check("o_cnt",       32'(o_cnt),       e.cnt);
                check("o_acc_en",    32'(o_acc_en),    32'(e.en));
                check("o_acc_clr",   32'(o_acc_clr),   32'(e.clr));
                check("o_out_valid", 32'(o_out_valid), 32'(e.ov));
                check("o_done",      32'(o_done),      32'(e.done));
            end
        end
        op = 32'(opd[PL-1]);
        for (int k = PL - 1; k > 0; k--) opd[k] = opd[k-1];
        opd[0] = i_data;
        if (o_acc_en === 1'b1) acc = (o_acc_clr === 1'b1 ? 32'd0 : acc) + op;
        if (o_out_valid === 1'b1 && i_out_ready === 1'b1) begin
            if (q_res.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL result_unexpected cyc=%0d actual=%0d expected=none", cyc, acc);
            end else begin
                check("result", acc, q_res.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (o_busy === 1'b0) break;
            n++;
            if (n > 2000) timeout_fail("wait_idle");
        end
        step();
    endtask

    // One reduction: start, len beats (optional bubbles), wait, handshake.
    task automatic run_job(input int len, input logic [15:0] bmask, input int hold,
                           input bit b2b, input bit stray, input bit seq_ops);
        int n;
        bit ok;
        if (!b2b) wait_idle();
        i_valid = 1'b0;
        i_start = 1'b1;
        i_len   = CW'(len);
        step();
        i_start = 1'b0;
        for (int b = 0; b < len; b++) begin
            if (b < 16 && bmask[b]) begin
                i_valid = 1'b0;
                step();
            end
            i_valid = 1'b1;
            i_data  = seq_ops ? 16'(b + 1) : 16'($urandom_range(255));
            i_start = stray ? 1'($urandom_range(1)) : 1'b0;
            i_len   = CW'($urandom);
            n = 0;
            do begin
                @(negedge clk);
                ok = (o_ready === 1'b1);
                step();
                n++;
                if (n > 50) timeout_fail("beat_accept");
            end while (!ok);
        end
        i_valid = 1'b0;
        i_start = 1'b0;
        n = 0;
        while (o_out_valid !== 1'b1) begin
            i_start = stray ? 1'($urandom_range(1)) : 1'b0;
            i_valid = stray ? 1'($urandom_range(1)) : 1'b0;
            i_len   = CW'($urandom);
            step();
            n++;
            if (n > PL + 10) timeout_fail("out_valid");
        end
        for (int h = 0; h < hold; h++) begin
            i_start = stray ? 1'($urandom_range(1)) : 1'b0;
            step();
        end
        i_out_ready = 1'b1;
        i_start     = stray;
        i_len       = CW'($urandom_range(1, 255));
        step();
        i_out_ready = 1'b0;
        i_start     = 1'b0;
        i_valid     = 1'b0;
    endtask

    initial begin
        #500000;
        timeout_fail("watchdog");
    end

    initial begin
        rst = 1'b1; i_start = 1'b0; i_len = '0; i_valid = 1'b0;
        i_out_ready = 1'b0; i_data = '0;
        for (int k = 0; k < PL; k++) opd[k] = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Operands 1..4 sum to 10.
        run_job(4, 16'h0000, 0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("sum_1to4", acc, 32'd10);
        // Bubble pattern 1,0,1,0,1,1.
        run_job(4, 16'h0006, 0, 1'b0, 1'b0, 1'b0);
        // Single-beat reduction.
        run_job(1, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        // Zero-length start is ignored.
        wait_idle();
        i_start = 1'b1; i_len = '0;
        step();
        i_start = 1'b0;
        repeat (3) step();
        // Backpressure for 5 cycles.
        run_job(5, 16'h0000, 5, 1'b0, 1'b0, 1'b0);
        // Stray starts everywhere, then a back-to-back job.
        run_job(6, 16'h0015, 3, 1'b0, 1'b1, 1'b0);
        run_job(3, 16'h0000, 1, 1'b1, 1'b0, 1'b0);
        // Reset mid-ACC after two of four beats.
        wait_idle();
        i_start = 1'b1; i_len = CW'(4);
        step();
        i_start = 1'b0; i_valid = 1'b1; i_data = 16'd7;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; i_valid = 1'b0;
        repeat (4) step();
        run_job(3, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        // Maximum length.
        run_job(255, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        // Random jobs.
        for (int j = 0; j < 40; j++) begin
            run_job(int'($urandom_range(1, 12)), 16'($urandom), int'($urandom_range(0, 4)),
                    1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
        end
        repeat (10) step();
        finish_run();
    end

endmodule
